// File: rtl/ahb_timer_pkg.sv
// ============================================================================
// ahb_timer_pkg : register map, bit indices, bus FSM states and decode helper.
// Optional feature macro: TIMER_PRESCALER_EN.   Revision 1.0
// ============================================================================
`default_nettype none

package ahb_timer_pkg;

  localparam logic [11:0] OFF_CTRL     = 12'h000;
  localparam logic [11:0] OFF_COUNT    = 12'h004;
  localparam logic [11:0] OFF_COMPARE  = 12'h008;
  localparam logic [11:0] OFF_STATUS   = 12'h00C;
  localparam logic [11:0] OFF_PRESCALE = 12'h010;

  localparam int CTRL_EN          = 0;
  localparam int CTRL_IRQ_EN      = 1;
  localparam int CTRL_AUTO_RELOAD = 2;
  localparam int STATUS_MATCH     = 0;

  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } bus_state_t;

  typedef enum logic [2:0] {
    REG_CTRL     = 3'd0,
    REG_COUNT    = 3'd1,
    REG_COMPARE  = 3'd2,
    REG_STATUS   = 3'd3,
    REG_PRESCALE = 3'd4,
    REG_NONE     = 3'd7
  } reg_sel_t;

  // Misaligned or unmapped offsets map to REG_NONE, which the bus answers with an error.
  function automatic reg_sel_t reg_decode(input logic [11:0] off);
    reg_sel_t s;
    s = REG_NONE;
    if (off[1:0] == 2'b00) begin
      case (off)
        OFF_CTRL:     s = REG_CTRL;
        OFF_COUNT:    s = REG_COUNT;
        OFF_COMPARE:  s = REG_COMPARE;
        OFF_STATUS:   s = REG_STATUS;
`ifdef TIMER_PRESCALER_EN
        OFF_PRESCALE: s = REG_PRESCALE;
`endif
        default:      s = REG_NONE;
      endcase
    end
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_timer_slave_if.sv
// ============================================================================
// ahb_timer_slave_if : simple AHB-style slave bus bundle with master/slave views.
// Revision 1.0
// ============================================================================
`default_nettype none

interface ahb_timer_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  hsel;
  logic [ADDR_WIDTH-1:0] haddr;
  logic                  hwrite;
  logic [DATA_WIDTH-1:0] hwdata;
  logic                  hready;
  logic                  hresp;
  logic [DATA_WIDTH-1:0] hrdata;

  modport master (
    output hsel, haddr, hwrite, hwdata,
    input  hready, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, hwrite, hwdata,
    output hready, hresp, hrdata
  );
endinterface

`default_nettype wire

// File: rtl/timer_counter.sv
// ============================================================================
// timer_counter : COUNT/COMPARE/CTRL/MATCH registers, reload and tick logic.
// Optional feature macro: TIMER_PRESCALER_EN (adds PRESCALE).   Revision 1.0
// ============================================================================
`default_nettype none

module timer_counter
  import ahb_timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_ctrl,
  input  logic        wr_count,
  input  logic        wr_compare,
  input  logic        wr_status,
`ifdef TIMER_PRESCALER_EN
  input  logic        wr_prescale,
  output logic [7:0]  prescale,
`endif
  input  logic [31:0] wdata,
  output logic [2:0]  ctrl,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        match,
  output logic        irq
);

  logic tick;
  logic en;
  logic hit;

  assign en  = ctrl[CTRL_EN];
  assign hit = en && tick && (count == compare);
  assign irq = match & ctrl[CTRL_IRQ_EN];

`ifdef TIMER_PRESCALER_EN
  logic [7:0] ps_cnt;

  assign tick = (ps_cnt == prescale);

  // The divider is held at zero while disabled so enabling starts a fresh period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale <= '0;
      ps_cnt   <= '0;
    end else begin
      if (wr_prescale) begin
        prescale <= wdata[7:0];
      end
      if (!en || tick) begin
        ps_cnt <= '0;
      end else begin
        ps_cnt <= ps_cnt + 8'd1;
      end
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl    <= '0;
      count   <= '0;
      compare <= COMPARE_RST;
      match   <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl <= wdata[2:0];
      end
      if (wr_compare) begin
        compare <= wdata;
      end
      // Bus write beats both the increment and the reload.
      if (wr_count) begin
        count <= wdata;
      end else if (en && tick) begin
        count <= (hit && ctrl[CTRL_AUTO_RELOAD]) ? 32'd0 : count + 32'd1;
      end
      // A hardware match beats a same-cycle write-1-to-clear.
      if (hit) begin
        match <= 1'b1;
      end else if (wr_status && wdata[STATUS_MATCH]) begin
        match <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ahb_timer_slave.sv
// ============================================================================
// ahb_timer_slave : bus FSM (IDLE/WAIT/RESP) and register decode for the timer.
// Optional feature macro: TIMER_PRESCALER_EN.   Revision 1.0
// ============================================================================
`default_nettype none

module ahb_timer_slave
  import ahb_timer_pkg::*;
#(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int AHB_DATA_WIDTH = 32,
  parameter int WAIT_STATES    = 1
) (
  input  logic             clk,
  input  logic             rst,
  ahb_timer_slave_if.slave bus,
  output logic             irq
);

  localparam int         DEC_BITS  = (AHB_ADDR_WIDTH < 12) ? AHB_ADDR_WIDTH : 12;
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES - 1);

  bus_state_t                state;
  logic [3:0]                wait_cnt;
  logic [DEC_BITS-1:0]       addr_q;
  logic                      write_q;
  logic [31:0]               wdata_q;
  logic                      hready_q;
  logic                      hresp_q;
  logic [AHB_DATA_WIDTH-1:0] hrdata_q;

  reg_sel_t    sel;
  logic        err;
  logic        wr_commit;
  logic [31:0] rd_data;

  logic [2:0]  ctrl;
  logic [31:0] count;
  logic [31:0] compare;
  logic        match;
`ifdef TIMER_PRESCALER_EN
  logic [7:0]  prescale;
`endif

  assign sel       = reg_decode(12'(addr_q));
  assign err       = (sel == REG_NONE);
  assign wr_commit = (state == ST_RESP) && write_q && !err;

  assign bus.hready = hready_q;
  assign bus.hresp  = hresp_q;
  assign bus.hrdata = hrdata_q;

  always_comb begin
    rd_data = '0;
    case (sel)
      REG_CTRL:     rd_data = {29'd0, ctrl};
      REG_COUNT:    rd_data = count;
      REG_COMPARE:  rd_data = compare;
      REG_STATUS:   rd_data = {31'd0, match};
`ifdef TIMER_PRESCALER_EN
      REG_PRESCALE: rd_data = {24'd0, prescale};
`endif
      default:      rd_data = '0;
    endcase
  end

  // Response outputs are registered: they pulse in the cycle after RESP,
  // which is also the IDLE cycle that can accept the next access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      hready_q <= 1'b0;
      hresp_q  <= 1'b0;
      hrdata_q <= '0;
    end else begin
      hready_q <= 1'b0;
      hresp_q  <= 1'b0;
      hrdata_q <= '0;
      case (state)
        ST_IDLE: begin
          if (bus.hsel) begin
            addr_q   <= bus.haddr[DEC_BITS-1:0];
            write_q  <= bus.hwrite;
            wdata_q  <= 32'(bus.hwdata);
            wait_cnt <= '0;
            state    <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            wait_cnt <= '0;
            state    <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ST_RESP: begin
          hready_q <= 1'b1;
          hresp_q  <= err;
          if (!write_q && !err) begin
            hrdata_q <= AHB_DATA_WIDTH'(rd_data);
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  timer_counter u_counter (
    .clk         (clk),
    .rst         (rst),
    .wr_ctrl     (wr_commit && (sel == REG_CTRL)),
    .wr_count    (wr_commit && (sel == REG_COUNT)),
    .wr_compare  (wr_commit && (sel == REG_COMPARE)),
    .wr_status   (wr_commit && (sel == REG_STATUS)),
`ifdef TIMER_PRESCALER_EN
    .wr_prescale (wr_commit && (sel == REG_PRESCALE)),
    .prescale    (prescale),
`endif
    .wdata       (wdata_q),
    .ctrl        (ctrl),
    .count       (count),
    .compare     (compare),
    .match       (match),
    .irq         (irq)
  );

endmodule

`default_nettype wire

// File: tb/tb_ahb_timer_slave.sv
// ============================================================================
// tb_ahb_timer_slave : scoreboard bench for ahb_timer_slave (WAIT_STATES=1).
// Optional feature macro: TIMER_PRESCALER_EN enables the prescaler scenario.
// ============================================================================
`default_nettype none

module tb_ahb_timer_slave;

  localparam int          WS        = 1;
  localparam logic [31:0] A_CTRL    = 32'h0000_0000;
  localparam logic [31:0] A_COUNT   = 32'h0000_0004;
  localparam logic [31:0] A_COMPARE = 32'h0000_0008;
  localparam logic [31:0] A_STATUS  = 32'h0000_000C;
  localparam logic [31:0] A_PRESC   = 32'h0000_0010;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        resp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  exp_t        sb[$];
  logic [31:0] cnt_q[$];

  ahb_timer_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  ahb_timer_slave #(
    .AHB_ADDR_WIDTH (32),
    .AHB_DATA_WIDTH (32),
    .WAIT_STATES    (WS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .irq (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One bus access; returns at the negedge where hready is observed (cyc = commit edge).
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_data, input logic exp_resp, output int r_edge);
    exp_t e;
    int   c0;
    bit   seen;
    bit   quiet_bad;
    e.addr = addr; e.data = exp_data; e.resp = exp_resp;
    sb.push_back(e);
    @(negedge clk);
    bus.hsel = 1'b1; bus.haddr = addr; bus.hwrite = wr; bus.hwdata = wdata;
    c0 = cyc; seen = 0; quiet_bad = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      bus.hsel = 1'b0;
      if (bus.hready === 1'b1) seen = 1;
      else if (bus.hresp !== 1'b0 || bus.hrdata !== 32'd0) quiet_bad = 1;
    end
    r_edge = cyc;
    e = sb.pop_front();
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL xfer_timeout addr=%h: hready=0 after 20 cycles, required 1", e.addr);
    end else begin
      checks++;
      if (cyc - c0 != WS + 2) begin
        failures++;
        $display("FAIL latency addr=%h: got %0d cycles, required %0d", e.addr, cyc - c0, WS + 2);
      end
      checks++;
      if (bus.hrdata !== e.data) begin
        failures++;
        $display("FAIL hrdata addr=%h: got %h, required %h", e.addr, bus.hrdata, e.data);
      end
      checks++;
      if (bus.hresp !== e.resp) begin
        failures++;
        $display("FAIL hresp addr=%h: got %b, required %b", e.addr, bus.hresp, e.resp);
      end
    end
    checks++;
    if (quiet_bad) begin
      failures++;
      $display("FAIL idle_outputs addr=%h: hresp/hrdata nonzero while hready=0, required 0", e.addr);
    end
  endtask

  // Compares the internal COUNT against queued expectations, one per cycle.
  task automatic probe_count(input string tag, input int n);
    logic [31:0] exp;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      exp = cnt_q.pop_front();
      checks++;
      if (dut.u_counter.count !== exp) begin
        failures++;
        $display("FAIL %s[%0d]: count got %h, required %h", tag, k, dut.u_counter.count, exp);
      end
    end
  endtask

  task automatic test_reset();
    bus.hsel = 1'b1; bus.haddr = A_COMPARE; bus.hwrite = 1'b0; bus.hwdata = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.hready !== 1'b0) begin failures++; $display("FAIL reset_hready: got %b, required 0", bus.hready); end
    checks++; if (bus.hresp !== 1'b0) begin failures++; $display("FAIL reset_hresp: got %b, required 0", bus.hresp); end
    checks++; if (bus.hrdata !== 32'd0) begin failures++; $display("FAIL reset_hrdata: got %h, required 0", bus.hrdata); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b, required 0", irq); end
    bus.hsel = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_read_after_reset();
    int r;
    xfer(1'b0, A_COMPARE, 32'd0, 32'hFFFF_FFFF, 1'b0, r);
    xfer(1'b0, A_CTRL,    32'd0, 32'd0,         1'b0, r);
    xfer(1'b0, A_COUNT,   32'd0, 32'd0,         1'b0, r);
    xfer(1'b0, A_STATUS,  32'd0, 32'd0,         1'b0, r);
  endtask

  task automatic test_auto_reload();
    int r, r2;
    xfer(1'b1, A_COMPARE, 32'd5, 32'd0, 1'b0, r);
    xfer(1'b0, A_COMPARE, 32'd0, 32'd5, 1'b0, r);
    xfer(1'b1, A_CTRL,    32'h7, 32'd0, 1'b0, r);
    for (int k = 0; k < 8; k++) cnt_q.push_back(32'(k % 6));
    probe_count("reload_seq", 8);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL irq_on_match: got %b, required 1", irq); end
    xfer(1'b1, A_CTRL, 32'h2, 32'd0, 1'b0, r2);
    xfer(1'b0, A_COUNT, 32'd0, 32'((r2 - r) % 6), 1'b0, r2);
    xfer(1'b0, A_CTRL,  32'd0, 32'h2, 1'b0, r2);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL irq_held: got %b, required 1", irq); end
    xfer(1'b1, A_STATUS, 32'd1, 32'd0, 1'b0, r2);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_w1c: got %b, required 0", irq); end
    xfer(1'b0, A_STATUS, 32'd0, 32'd0, 1'b0, r2);
  endtask

  task automatic test_wrap();
    int r, r2;
    xfer(1'b1, A_COUNT, 32'hFFFF_FFFE, 32'd0, 1'b0, r);
    xfer(1'b1, A_CTRL,  32'h1,         32'd0, 1'b0, r);
    for (int k = 0; k < 4; k++) cnt_q.push_back(32'hFFFF_FFFE + 32'(k));
    probe_count("wrap_seq", 4);
    xfer(1'b0, A_COUNT, 32'd0, 32'hFFFF_FFFE + 32'(cyc + 3 - r), 1'b0, r2);
    xfer(1'b1, A_CTRL,  32'd0, 32'd0, 1'b0, r2);
  endtask

  task automatic test_errors();
    int r;
    xfer(1'b0, 32'h0000_0014, 32'd0,       32'd0, 1'b1, r);
    xfer(1'b0, 32'h0000_0002, 32'd0,       32'd0, 1'b1, r);
    xfer(1'b1, 32'h0000_000A, 32'h1234,    32'd0, 1'b1, r);
    xfer(1'b1, 32'h0000_0014, 32'hDEAD,    32'd0, 1'b1, r);
`ifndef TIMER_PRESCALER_EN
    xfer(1'b0, A_PRESC,       32'd0,       32'd0, 1'b1, r);
`endif
    xfer(1'b0, A_COMPARE,     32'd0,       32'd5, 1'b0, r);
    xfer(1'b0, A_CTRL,        32'd0,       32'd0, 1'b0, r);
  endtask

  // Second access is started by hsel held high in the IDLE cycle carrying hready.
  task automatic test_back_to_back();
    exp_t        e;
    logic [31:0] addrs [2];
    int          c0;
    bit          seen;
    addrs[0] = A_COMPARE; addrs[1] = A_CTRL;
    e.addr = A_COMPARE; e.data = 32'd5; e.resp = 1'b0; sb.push_back(e);
    e.addr = A_CTRL;    e.data = 32'd0; e.resp = 1'b0; sb.push_back(e);
    @(negedge clk);
    bus.hsel = 1'b1; bus.hwrite = 1'b0; bus.haddr = addrs[0];
    c0 = cyc;
    for (int t = 0; t < 2; t++) begin
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (t == 1) bus.hsel = 1'b0;
        if (bus.hready === 1'b1) seen = 1;
      end
      e = sb.pop_front();
      checks++;
      if (!seen || cyc - c0 != WS + 2) begin
        failures++;
        $display("FAIL b2b_latency[%0d]: got %0d cycles, required %0d", t, cyc - c0, WS + 2);
      end
      checks++;
      if (bus.hrdata !== e.data || bus.hresp !== e.resp) begin
        failures++;
        $display("FAIL b2b_data[%0d]: got %h/%b, required %h/%b", t, bus.hrdata, bus.hresp, e.data, e.resp);
      end
      bus.haddr = addrs[1];
      c0 = cyc;
    end
    @(negedge clk);
    checks++;
    if (bus.hready !== 1'b0) begin failures++; $display("FAIL b2b_pulse_width: hready got %b, required 0", bus.hready); end
  endtask

  task automatic test_reset_abort();
    int r;
    bit pulsed;
    @(negedge clk);
    bus.hsel = 1'b1; bus.haddr = A_COMPARE; bus.hwrite = 1'b1; bus.hwdata = 32'h10;
    @(negedge clk);
    bus.hsel = 1'b0;
    rst = 1'b1;
    pulsed = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.hready !== 1'b0) pulsed = 1;
    end
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.hready !== 1'b0) pulsed = 1;
    end
    checks++;
    if (pulsed) begin failures++; $display("FAIL abort_hready: got a pulse, required none"); end
    xfer(1'b0, A_COMPARE, 32'd0, 32'hFFFF_FFFF, 1'b0, r);
  endtask

`ifdef TIMER_PRESCALER_EN
  task automatic test_prescaler();
    int r;
    xfer(1'b0, A_PRESC, 32'd0, 32'd0, 1'b0, r);
    xfer(1'b1, A_PRESC, 32'd3, 32'd0, 1'b0, r);
    xfer(1'b0, A_PRESC, 32'd0, 32'd3, 1'b0, r);
    xfer(1'b1, A_CTRL,  32'h1, 32'd0, 1'b0, r);
    for (int k = 0; k < 13; k++) cnt_q.push_back(32'(k / 4));
    probe_count("presc_seq", 13);
    xfer(1'b1, A_CTRL,  32'd0, 32'd0, 1'b0, r);
  endtask
`endif

  initial begin
    bus.hsel = 1'b0; bus.haddr = '0; bus.hwrite = 1'b0; bus.hwdata = '0;
    test_reset();
    test_read_after_reset();
    test_auto_reload();
    test_wrap();
    test_errors();
    test_back_to_back();
    test_reset_abort();
`ifdef TIMER_PRESCALER_EN
    test_prescaler();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ahb_timer_slave.md
AHB_TIMER_SLAVE -- requirements
Module: ahb_timer_slave

Interface
REQ-001 The block SHALL have parameter AHB_ADDR_WIDTH, default 32: width of haddr.
REQ-002 The block SHALL have parameter AHB_DATA_WIDTH, default 32: width of hwdata/hrdata.
REQ-003 The block SHALL have parameter WAIT_STATES, default 1, range 0..15: wait cycles inserted before the response.
REQ-004 The block SHALL have port clk, input, 1: sole clock; all state on rising edge.
REQ-005 The block SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 The block SHALL have port hsel, input, 1: slave select from the fabric.
REQ-007 The block SHALL have port haddr, input, AHB_ADDR_WIDTH: access address; low 12 bits decoded.
REQ-008 The block SHALL have port hwrite, input, 1: 1 = write, 0 = read.
REQ-009 The block SHALL have port hwdata, input, AHB_DATA_WIDTH: write data.
REQ-010 The block SHALL have port hready, output, 1: one-cycle transfer-complete pulse.
REQ-011 The block SHALL have port hresp, output, 1: error flag, valid only while hready=1.
REQ-012 The block SHALL have port hrdata, output, AHB_DATA_WIDTH: read data, valid only while hready=1.
REQ-013 The block SHALL have port irq, output, 1: level interrupt.

Function
REQ-014 The block SHALL run an FSM with states IDLE, WAIT and RESP.
REQ-015 In IDLE with hsel=1, the block SHALL latch haddr, hwrite and hwdata, then go to WAIT, or to RESP if WAIT_STATES=0.
REQ-016 In WAIT the block SHALL count WAIT_STATES cycles, then enter RESP.
REQ-017 In RESP the block SHALL drive hready=1 for exactly one cycle, commit a write or drive hrdata for a read, then return to IDLE.
REQ-018 hsel still high in that IDLE cycle SHALL start a new access; access latency is WAIT_STATES+2 cycles from hsel sampled to hready.
REQ-019 hsel changes outside IDLE SHALL be ignored.
REQ-020 Register map (haddr[11:0]) SHALL be: 0x000 CTRL (bit0 EN, bit1 IRQ_EN, bit2 AUTO_RELOAD, others read 0); 0x004 COUNT RW; 0x008 COMPARE RW; 0x00C STATUS (bit0 MATCH, write-1-to-clear).
REQ-021 Any other offset, or haddr[1:0]!=0, SHALL give hresp=1, hrdata=0 and no register change.
REQ-022 hrdata and hresp SHALL be 0 whenever hready=0.
REQ-023 With EN=1, COUNT SHALL increment by 1 per tick, wrapping 0xFFFFFFFF -> 0.
REQ-024 With EN=1 and COUNT==COMPARE, MATCH SHALL be set; with AUTO_RELOAD=1, COUNT SHALL load 0 on that tick instead of incrementing.
REQ-025 A bus write to COUNT SHALL win over a same-cycle increment or reload.
REQ-026 A hardware MATCH set SHALL win over a same-cycle W1C.
REQ-027 irq SHALL equal MATCH & IRQ_EN, registered-free, combinational from state bits.
REQ-028 A tick SHALL be every clk cycle unless the prescaler is compiled in.

Reset
REQ-029 rst=1 SHALL asynchronously force FSM=IDLE, wait counter=0, CTRL=0, COUNT=0, COMPARE=0xFFFFFFFF, MATCH=0, PRESCALE=0, prescale counter=0.
REQ-030 During reset, hready, hresp, hrdata and irq SHALL be 0.
REQ-031 Reset mid-access SHALL abort the access with no hready pulse and no write committed.

Configuration
REQ-032 With TIMER_PRESCALER_EN defined, a register PRESCALE (bits[7:0] RW) SHALL exist at 0x010, and a tick SHALL occur when an internal 8-bit prescale counter equals PRESCALE, the counter then resetting to 0.
REQ-033 With TIMER_PRESCALER_EN defined, PRESCALE=0 SHALL give one tick per cycle.
REQ-034 Without TIMER_PRESCALER_EN, offset 0x010 SHALL return an error like any unmapped offset, and no prescaler logic SHALL exist.

Structure
REQ-035 Package ahb_timer_pkg SHALL hold register offsets, CTRL/STATUS bit indices, the FSM state enum and the COMPARE reset value.
REQ-036 Counter, compare, reload and prescaler logic SHALL live in sub-module timer_counter; the top SHALL hold the bus FSM and decode.

Verification
REQ-037 The bench SHALL cover: WAIT_STATES=1, read 0x008 after reset -> hready exactly 3 cycles after hsel, hrdata=0xFFFFFFFF, hresp=0.
REQ-038 The bench SHALL cover: write COMPARE=5, CTRL=0x7 -> COUNT runs 0..5, MATCH set, COUNT reloads to 0, irq=1; write STATUS=1 -> irq=0.
REQ-039 The bench SHALL cover: write COUNT=0xFFFFFFFE, CTRL=0x1 -> COUNT wraps through 0xFFFFFFFF to 0x0, 0x1.
REQ-040 The bench SHALL cover: read 0x014, and read 0x002 -> hready with hresp=1, hrdata=0; registers unchanged.
REQ-041 The bench SHALL cover: assert rst during WAIT of a write to COMPARE=0x10 -> no hready, COMPARE stays 0xFFFFFFFF.
REQ-042 The bench SHALL cover, with TIMER_PRESCALER_EN: PRESCALE=3, EN=1 -> COUNT increments once per 4 cycles.
